// File: rtl/viterbi_traceback_ctrl_if.sv
// Bundles the traceback controller's start request, backpointer read port and
// tag output stream. The slave modport is the controller side.
interface viterbi_traceback_ctrl_if #(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4
);
  logic                    start;
  logic [word_num_bit:0]   word_len;
  logic [POS_num_bit-1:0]  final_pos;
  logic                    rd_en;
  logic [word_num_bit-1:0] rd_word;
  logic [POS_num_bit-1:0]  rd_pos;
  logic [POS_num-1:0]      rd_data;
  logic                    tag_valid;
  logic [word_num_bit-1:0] tag_word;
  logic [POS_num_bit-1:0]  tag_pos;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [word_num_bit:0]   multi_cnt;

  modport slave (
    input  start, word_len, final_pos, rd_data,
    output rd_en, rd_word, rd_pos, tag_valid, tag_word, tag_pos,
           busy, done, error, multi_cnt
  );

  modport master (
    output start, word_len, final_pos, rd_data,
    input  rd_en, rd_word, rd_pos, tag_valid, tag_word, tag_pos,
           busy, done, error, multi_cnt
  );
endinterface

// File: rtl/viterbi_traceback_ctrl.sv
// Viterbi traceback sequencer: walks predecessor vectors from the last word back
// to word 0, emitting one POS tag per word and counting multi-hot vectors.
module viterbi_traceback_ctrl #(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  viterbi_traceback_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RESOLVE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [word_num_bit:0]   LP_LEN_ONE = 1;
  localparam logic [word_num_bit:0]   LP_LEN_MAX = word_num[word_num_bit:0];
  localparam logic [POS_num_bit:0]    LP_POS_LIM = POS_num[POS_num_bit:0];
  localparam logic [word_num_bit-1:0] LP_T_ONE   = 1;
  localparam logic [word_num_bit:0]   LP_CNT_TWO = 2;

  state_t                  r_state, w_next_state;
  logic [word_num_bit-1:0] r_t;
  logic [POS_num_bit-1:0]  r_cur;
  logic                    r_tag_valid;
  logic [word_num_bit-1:0] r_tag_word;
  logic [POS_num_bit-1:0]  r_tag_pos;
  logic                    r_error;
  logic [word_num_bit:0]   r_multi_cnt;

  logic                    w_args_ok;
  logic                    w_load;
  logic                    w_step;
  logic [word_num_bit:0]   w_len_m1;
  logic [word_num_bit:0]   w_ones;
  logic [POS_num_bit-1:0]  w_sel;

  assign w_args_ok = (bus.word_len != '0) && (bus.word_len <= LP_LEN_MAX) &&
                     ({1'b0, bus.final_pos} < LP_POS_LIM);
  assign w_len_m1  = bus.word_len - LP_LEN_ONE;

  // Descending scan so the last assignment wins: lowest-indexed set bit.
  always_comb begin
    w_ones = '0;
    w_sel  = '0;
    for (int i = POS_num - 1; i >= 0; i--) begin
      w_ones = w_ones + {{word_num_bit{1'b0}}, bus.rd_data[i]};
      if (bus.rd_data[i]) w_sel = i[POS_num_bit-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE, S_ERR: begin
        if (bus.start) begin
          if (w_args_ok) begin
            w_load       = 1'b1;
            w_next_state = (bus.word_len > LP_LEN_ONE) ? S_READ : S_DONE;
          end else begin
            w_next_state = S_ERR;
          end
        end
      end
      S_READ:    w_next_state = S_RESOLVE;
      S_RESOLVE: begin
        if (w_ones == '0) begin
          w_next_state = S_ERR;
        end else begin
          w_step       = 1'b1;
          w_next_state = (r_t == LP_T_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t         <= '0;
      r_cur       <= '0;
      r_tag_valid <= 1'b0;
      r_tag_word  <= '0;
      r_tag_pos   <= '0;
      r_error     <= 1'b0;
      r_multi_cnt <= '0;
    end else begin
      r_tag_valid <= 1'b0;
      if (w_load) begin
        r_t         <= w_len_m1[word_num_bit-1:0];
        r_cur       <= bus.final_pos;
        r_tag_valid <= 1'b1;
        r_tag_word  <= w_len_m1[word_num_bit-1:0];
        r_tag_pos   <= bus.final_pos;
        r_error     <= 1'b0;
        r_multi_cnt <= '0;
      end else if (w_step) begin
        r_t         <= r_t - LP_T_ONE;
        r_cur       <= w_sel;
        r_tag_valid <= 1'b1;
        r_tag_word  <= r_t - LP_T_ONE;
        r_tag_pos   <= w_sel;
        if ((w_ones >= LP_CNT_TWO) && (r_multi_cnt != '1))
          r_multi_cnt <= r_multi_cnt + LP_LEN_ONE;
      end else if (w_next_state == S_ERR) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.rd_en     = (r_state == S_READ);
  assign bus.rd_word   = r_t;
  assign bus.rd_pos    = r_cur;
  assign bus.tag_valid = r_tag_valid;
  assign bus.tag_word  = r_tag_word;
  assign bus.tag_pos   = r_tag_pos;
  assign bus.busy      = (r_state == S_READ) || (r_state == S_RESOLVE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.error     = r_error;
  assign bus.multi_cnt = r_multi_cnt;

endmodule

// File: doc/viterbi_traceback_ctrl.md
Name: viterbi_traceback_ctrl

Overview:
Sequences the Viterbi traceback for one sentence. Starting from the final POS state, it walks backwards through the stored predecessor vectors, one word per step, and emits one POS tag per word. It resolves multi-hot predecessor vectors deterministically and counts how often that happens. It sits between the backpointer memory (read port driven here) and the tag output buffer.

Parameters:
word_num, 16, maximum words per sentence
word_num_bit, 4, log2(word_num)
POS_num, 11, number of POS states
POS_num_bit, 4, width of a POS index

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  start request; sampled only in IDLE or ERR
word_len  in  word_num_bit+1  sentence length L; legal range 1..word_num
final_pos  in  POS_num_bit  POS state of the last word; legal range 0..POS_num-1
rd_en  out  1  backpointer memory read strobe
rd_word  out  word_num_bit  word index being read
rd_pos  out  POS_num_bit  POS state being read
rd_data  in  POS_num  predecessor vector; valid the cycle after rd_en
tag_valid  out  1  one-cycle pulse, tag_word/tag_pos valid
tag_word  out  word_num_bit  word index of the emitted tag
tag_pos  out  POS_num_bit  POS tag
busy  out  1  high in READ and RESOLVE
done  out  1  one-cycle completion pulse
error  out  1  sticky error flag
multi_cnt  out  word_num_bit+1  count of multi-hot vectors in the current sentence

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, including mid-sentence: state goes to IDLE. All outputs and internal registers go to 0. Any sentence in progress is abandoned.
- States:
  - IDLE: waiting for start.
  - READ: rd_en=1. rd_word = t and rd_pos = cur, both from registers.
  - RESOLVE: rd_data is consumed.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - ERR: error=1 and busy=0. Stay until a new start is accepted.
- Start in IDLE/ERR, legal arguments, at edge E0:
  - t = L-1, cur = final_pos, multi_cnt = 0, error = 0.
  - Tag output: tag_valid=1, tag_word=L-1, tag_pos=final_pos.
  - Next state: READ if L>1, else DONE.
- Start with illegal arguments (L=0, L>word_num, or final_pos>=POS_num):
  - Go to ERR with error=1.
  - No tag is emitted and done is not asserted.
- start is ignored in READ, RESOLVE and DONE.
- READ: always goes to RESOLVE on the next edge.
- RESOLVE, at the edge:
  - n = popcount(rd_data), computed at least word_num_bit wide.
  - n=0: go to ERR, no tag emitted.
  - n>=1: sel = lowest-indexed set bit. If n>=2, multi_cnt increments; it saturates at all-ones and never wraps.
  - Register the tag: tag_valid=1, tag_word=t-1, tag_pos=sel.
  - Update cur=sel and t=t-1.
  - Next state: DONE if the new t is 0, else READ.
- Throughput and timing:
  - 2 cycles per traceback step.
  - L words take tags at E0, E2, ..., E(2L-2).
  - done is high in the cycle after the last tag edge, coincident with the last tag_valid.
- Tags are emitted in descending tag_word order, L-1 down to 0, each exactly once.
- tag_valid is high only in the cycle after a tag edge; tag_word and tag_pos hold their values otherwise.
- multi_cnt holds its value until the next accepted start.
- rd_data is ignored outside RESOLVE.

Test Plan:
- L=1, final_pos=5 -> one cycle after E0: tag_valid=1, tag_word=0, tag_pos=5, done=1, rd_en never asserted.
- L=4, final_pos=2; one-hot rd_data gives predecessors 7, 3, 0 -> tags (3,2), (2,7), (1,3), (0,0) at E0/E2/E4/E6. rd_word sequence is 3, 2, 1 and rd_pos sequence is 2, 7, 3. done follows E6 and multi_cnt=0.
- L=3, first rd_data=11'b00100100100, second one-hot bit 9 -> tags (2,x), (1,2), (0,9), multi_cnt=1, done asserted.
- L=5, second rd_data=0 -> ERR after 2 tags, error=1, busy=0, no done. A new legal start clears error and completes normally.
- word_len=17 or final_pos=11 -> ERR, error=1, no tag_valid. start pulsed while busy in an L=4 run -> ignored, and the run completes unchanged.
- rst asserted mid-READ of an L=8 run -> all outputs 0 immediately, state IDLE. A subsequent start of L=2 runs correctly.
